nib_deser4: RTL and testbench
=============================

Name: nib_deser4

Overview:
Serial-to-parallel nibble receiver. It collects 4 serial bits into a 4-bit word and presents the word on a valid/ready output handshake. It also provides the 4-input NAND of the completed word (nand_y), so gate-level checks can consume both the parallel word and its NAND reduction. It sits between a 1-bit serial source and any 4-input logic stage.

Parameters:
MSB_FIRST, 1, 1: first received bit lands in data[3]; 0: first bit lands in data[0].
DROP_ON_FULL, 1, 1: bits arriving while a word is held are dropped and flagged; 0: sin_ready deasserts instead (backpressure).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
sin_valid  input  1  serial bit present this cycle.
sin_bit  input  1  serial data bit.
sin_ready  output  1  receiver can accept a bit this cycle.
out_valid  output  1  out_data holds a complete word.
out_ready  input  1  consumer accepts the word.
out_data  output  4  assembled word.
nand_y  output  1  ~(out_data[3] & out_data[2] & out_data[1] & out_data[0]); meaningful only while out_valid=1.
overrun  output  1  sticky: a bit was dropped while holding; cleared only by rst.

Behaviour:
- Reset (rst=1 at a clk edge): state=COLLECT, bit count=0, shift reg=0, out_valid=0, out_data=0, nand_y=1, overrun=0, sin_ready=1.
- Bit acceptance: a bit is accepted on an edge where sin_valid & sin_ready.
- COLLECT state:
  - sin_ready=1.
  - Each accepted bit shifts into the register per MSB_FIRST and increments count.
  - The 4th accepted bit (count==3) loads out_data, sets out_valid=1 on the same edge, resets count to 0 and moves to HOLD.
  - Latency: out_valid rises on the edge that accepts bit 4. No extra cycle.
- HOLD state:
  - out_valid=1; out_data and nand_y are stable until the handshake.
  - out_valid & out_ready completes the handshake: next state=COLLECT, out_valid=0.
  - Simultaneous handshake and sin_valid in HOLD: the bit is accepted as bit 1 of the next word (zero-bubble streaming). sin_ready=out_ready in this case.
  - DROP_ON_FULL=1, out_ready=0: sin_ready=1 and the bit is discarded; overrun is set.
  - DROP_ON_FULL=0, out_ready=0: sin_ready=0; nothing is dropped and overrun stays 0.
- Throughput: one word per 4 accepted bits at full rate with out_ready held high.
- sin_valid gaps in COLLECT: partial state is held indefinitely with no timeout.
- rst mid-word or mid-HOLD: partial bits and the held word are discarded and out_valid drops on that edge.
- nand_y is combinational from registered out_data; there is no separate register.

Optional Feature:
NIB_DESER4_PARITY_EN
- Defined:
  - A 5th serial bit (even parity over the 4 data bits) follows each word.
  - HOLD is entered only after the parity bit is accepted.
  - Adds output parity_err (1 bit), registered alongside out_data and valid with out_valid.
  - The word is still delivered when parity fails.
- Undefined: 4-bit framing only, and the parity_err port does not exist.

Decomposition:
- Package nib_deser4_pkg:
  - state enum {COLLECT, HOLD}
  - NIB_W=4
  - CNT_W=3 (covers parity framing)
  - FRAME_LEN function (4 or 5 depending on the macro).
- Sub-module nib_deser4_shreg: shift register plus bit counter with MSB_FIRST ordering, exposing load_done. The top level owns the FSM, handshake, overrun and the nand_y gate.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> out_valid=0, out_data=0, nand_y=1, overrun=0, sin_ready=1.
- MSB_FIRST=1, bits 1,0,1,1 back-to-back, out_ready=1 -> out_data=4'b1011, nand_y=1, out_valid high exactly 1 cycle, on the 4th accept edge.
- Bits 1,1,1,1 -> out_data=4'hF, nand_y=0. With MSB_FIRST=0, bits 1,0,0,0 -> out_data=4'b0001.
- Hold out_ready=0 after a word, drive 2 more bits: DROP_ON_FULL=1 -> word unchanged, overrun=1; DROP_ON_FULL=0 -> sin_ready=0, overrun=0. Then out_ready=1 -> handshake; the next 4 bits form a fresh word.
- Continuous stream of 12 bits with out_ready=1 -> 3 words, no bubbles, including handshake and bit-1 acceptance on the same edge.
- rst asserted after 2 of 4 bits, then 4 new bits (0,1,1,0) -> out_data=4'b0110. With NIB_DESER4_PARITY_EN, data 1011 + parity 0 -> parity_err=1; parity 1 -> parity_err=0.

Source files
------------

// File: rtl/nib_deser4_pkg.sv
// Shared types and framing constants for the nib_deser4 nibble receiver.
// Optional macro NIB_DESER4_PARITY_EN extends each frame with an even-parity bit.
package nib_deser4_pkg;

   localparam int NIB_W = 4;
   localparam int CNT_W = 3;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   // Number of serial bits making up one frame on the wire.
   function automatic logic [CNT_W-1:0] FRAME_LEN();
`ifdef NIB_DESER4_PARITY_EN
      return 3'd5;
`else
      return 3'd4;
`endif
   endfunction

endpackage

// File: rtl/nib_deser4_if.sv
// Serial-in / parallel-out handshake bundle for nib_deser4.
// parity_err exists only when NIB_DESER4_PARITY_EN is defined.
interface nib_deser4_if;
   import nib_deser4_pkg::*;

   logic             sin_valid;
   logic             sin_bit;
   logic             sin_ready;
   logic             out_valid;
   logic             out_ready;
   logic [NIB_W-1:0] out_data;
`ifdef NIB_DESER4_PARITY_EN
   logic             parity_err;
`endif

   // master is the bit source plus word consumer; slave is the receiver.
`ifdef NIB_DESER4_PARITY_EN
   modport master (
      output sin_valid, sin_bit, out_ready,
      input  sin_ready, out_valid, out_data, parity_err
   );
   modport slave (
      input  sin_valid, sin_bit, out_ready,
      output sin_ready, out_valid, out_data, parity_err
   );
`else
   modport master (
      output sin_valid, sin_bit, out_ready,
      input  sin_ready, out_valid, out_data
   );
   modport slave (
      input  sin_valid, sin_bit, out_ready,
      output sin_ready, out_valid, out_data
   );
`endif

endinterface

// File: rtl/nib_deser4_shreg.sv
// Shift register and frame bit counter for nib_deser4; MSB_FIRST picks bit ordering.
// With NIB_DESER4_PARITY_EN the final frame bit is a parity bit and is not shifted in.
module nib_deser4_shreg
   import nib_deser4_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             bit_in,
   output logic [NIB_W-1:0] word_nxt,
`ifdef NIB_DESER4_PARITY_EN
   output logic             parity_err_nxt,
`endif
   output logic             load_done
);

   localparam logic [CNT_W-1:0] DATA_BITS = 3'd4;

   logic [NIB_W-1:0] word_q;
   logic [NIB_W-1:0] shifted;
   logic [CNT_W-1:0] count_q;

   // word_nxt is the value the word takes if this cycle's bit is accepted, so
   // the top can capture a finished word on the very edge that completes it.
   always_comb begin
      shifted   = MSB_FIRST ? {word_q[NIB_W-2:0], bit_in}
                            : {bit_in, word_q[NIB_W-1:1]};
      word_nxt  = (count_q < DATA_BITS) ? shifted : word_q;
      load_done = shift_en && (count_q == (FRAME_LEN() - 3'd1));
   end

`ifdef NIB_DESER4_PARITY_EN
   // Even parity: data ones plus the parity bit must total an even count.
   always_comb begin
      parity_err_nxt = (^word_q) ^ bit_in;
   end
`endif

   // Accumulate bits; a completed frame empties the register for the next word.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q  <= '0;
         count_q <= '0;
      end else if (load_done) begin
         word_q  <= '0;
         count_q <= '0;
      end else if (shift_en) begin
         word_q  <= word_nxt;
         count_q <= count_q + 3'd1;
      end
   end

endmodule

// File: rtl/nib_deser4.sv
// nib_deser4: serial-to-parallel nibble receiver with valid/ready output and NAND of the word.
// Optional macro NIB_DESER4_PARITY_EN adds a trailing even-parity bit and parity_err output.
module nib_deser4
   import nib_deser4_pkg::*;
#(
   parameter bit MSB_FIRST    = 1'b1,
   parameter bit DROP_ON_FULL = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   nib_deser4_if.slave  bus,
   output logic         nand_y,
   output logic         overrun
);

   state_t           state_q;
   state_t           state_d;
   logic             shift_en;
   logic             drop;
   logic             load_done;
   logic [NIB_W-1:0] word_nxt;
   logic [NIB_W-1:0] data_q;
`ifdef NIB_DESER4_PARITY_EN
   logic             parity_err_nxt;
   logic             parity_err_q;
`endif

   nib_deser4_shreg #(
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk            (clk),
      .rst            (rst),
      .shift_en       (shift_en),
      .bit_in         (bus.sin_bit),
      .word_nxt       (word_nxt),
`ifdef NIB_DESER4_PARITY_EN
      .parity_err_nxt (parity_err_nxt),
`endif
      .load_done      (load_done)
   );

   // A completing handshake frees HOLD in the same cycle, so the incoming bit
   // can start the next word; otherwise HOLD either drops bits or stalls.
   assign bus.sin_ready = (state_q == COLLECT) || bus.out_ready || DROP_ON_FULL;
   assign shift_en      = bus.sin_valid && ((state_q == COLLECT) || bus.out_ready);
   assign drop          = bus.sin_valid && (state_q == HOLD) && !bus.out_ready
                          && DROP_ON_FULL;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: if (load_done)     state_d = HOLD;
         HOLD:    if (bus.out_ready) state_d = COLLECT;
         default:                    state_d = COLLECT;
      endcase
   end

   // The word register only changes on the frame-completing edge, keeping it
   // stable for the whole HOLD period.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else if (load_done) begin
         data_q <= word_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end
   end

`ifdef NIB_DESER4_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err_q <= 1'b0;
      end else if (load_done) begin
         parity_err_q <= parity_err_nxt;
      end
   end

   assign bus.parity_err = parity_err_q;
`endif

   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_data  = data_q;
   assign nand_y        = ~&data_q;

endmodule

// File: tb/tb_nib_deser4.sv
// Scoreboard bench for nib_deser4: an MSB-first/drop instance and an LSB-first/backpressure instance.
// Honours NIB_DESER4_PARITY_EN by sending a parity bit after each word.
module tb_nib_deser4;
   import nib_deser4_pkg::*;

`ifdef NIB_DESER4_PARITY_EN
   localparam int FRAME_BITS = 5;
`else
   localparam int FRAME_BITS = 4;
`endif

   typedef struct {
      logic [3:0] bits;
      logic       par;
      logic [3:0] exp_a;
      logic [3:0] exp_b;
      logic       exp_nand;
      logic       exp_perr;
   } vec_t;

   typedef struct {
      logic [3:0] data;
      logic       nand_v;
      logic       perr;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic nand_a, nand_b, ovr_a, ovr_b;

   vec_t vecs [11];
   exp_t qa [$];
   exp_t qb [$];
   exp_t ea, eb;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   nib_deser4_if a_if ();
   nib_deser4_if b_if ();

   nib_deser4 #(
      .MSB_FIRST    (1'b1),
      .DROP_ON_FULL (1'b1)
   ) dut_a (
      .clk     (clk),
      .rst     (rst),
      .bus     (a_if),
      .nand_y  (nand_a),
      .overrun (ovr_a)
   );

   nib_deser4 #(
      .MSB_FIRST    (1'b0),
      .DROP_ON_FULL (1'b0)
   ) dut_b (
      .clk     (clk),
      .rst     (rst),
      .bus     (b_if),
      .nand_y  (nand_b),
      .overrun (ovr_b)
   );

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic driveBit(input logic b);
      a_if.sin_valid = 1'b1;
      a_if.sin_bit   = b;
      b_if.sin_valid = 1'b1;
      b_if.sin_bit   = b;
   endtask

   task automatic driveIdle();
      a_if.sin_valid = 1'b0;
      a_if.sin_bit   = 1'b0;
      b_if.sin_valid = 1'b0;
      b_if.sin_bit   = 1'b0;
   endtask

   task automatic setReady(input logic r);
      a_if.out_ready = r;
      b_if.out_ready = r;
   endtask

   // Sends one frame back-to-back; sin_valid is left high so frames can stream.
   task automatic applyStimulus(input int idx, input logic ready, input bit push);
      logic [4:0] frame;
      frame = {vecs[idx].bits, vecs[idx].par};
      setReady(ready);
      if (push) begin
         qa.push_back('{vecs[idx].exp_a, vecs[idx].exp_nand, vecs[idx].exp_perr});
         qb.push_back('{vecs[idx].exp_b, vecs[idx].exp_nand, vecs[idx].exp_perr});
      end
      for (int i = 0; i < FRAME_BITS; i++) begin
         driveBit(frame[4-i]);
         @(posedge clk);
         #1;
         if (i == 0) begin
            checkOutput("valid_low_after_bit1_a", {7'h0, a_if.out_valid}, 8'h0);
            checkOutput("valid_low_after_bit1_b", {7'h0, b_if.out_valid}, 8'h0);
         end
         if (i == FRAME_BITS - 1) begin
            checkOutput("valid_on_last_bit_a", {7'h0, a_if.out_valid}, 8'h1);
            checkOutput("valid_on_last_bit_b", {7'h0, b_if.out_valid}, 8'h1);
         end
      end
   endtask

   // Scoreboard monitor: every completed handshake must match the oldest expected word.
   always @(negedge clk) begin
      if (rst === 1'b0 && a_if.out_valid && a_if.out_ready) begin
         if (qa.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_word_a: got %0h, expected no word", a_if.out_data);
         end else begin
            ea = qa.pop_front();
            checkOutput("data_a", {4'h0, a_if.out_data}, {4'h0, ea.data});
            checkOutput("nand_a", {7'h0, nand_a}, {7'h0, ea.nand_v});
`ifdef NIB_DESER4_PARITY_EN
            checkOutput("perr_a", {7'h0, a_if.parity_err}, {7'h0, ea.perr});
`endif
         end
      end
      if (rst === 1'b0 && b_if.out_valid && b_if.out_ready) begin
         if (qb.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_word_b: got %0h, expected no word", b_if.out_data);
         end else begin
            eb = qb.pop_front();
            checkOutput("data_b", {4'h0, b_if.out_data}, {4'h0, eb.data});
            checkOutput("nand_b", {7'h0, nand_b}, {7'h0, eb.nand_v});
`ifdef NIB_DESER4_PARITY_EN
            checkOutput("perr_b", {7'h0, b_if.parity_err}, {7'h0, eb.perr});
`endif
         end
      end
   end

   initial begin
      //                bits     par   exp_a    exp_b    nand  perr
      vecs[0]  = '{4'b1011, 1'b0, 4'b1011, 4'b1101, 1'b1, 1'b1};
      vecs[1]  = '{4'b1011, 1'b1, 4'b1011, 4'b1101, 1'b1, 1'b0};
      vecs[2]  = '{4'b1111, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0};
      vecs[3]  = '{4'b1000, 1'b1, 4'b1000, 4'b0001, 1'b1, 1'b0};
      vecs[4]  = '{4'b0110, 1'b0, 4'b0110, 4'b0110, 1'b1, 1'b0};
      vecs[5]  = '{4'b0011, 1'b0, 4'b0011, 4'b1100, 1'b1, 1'b0};
      vecs[6]  = '{4'b0101, 1'b0, 4'b0101, 4'b1010, 1'b1, 1'b0};
      vecs[7]  = '{4'b1100, 1'b0, 4'b1100, 4'b0011, 1'b1, 1'b0};
      vecs[8]  = '{4'b1001, 1'b0, 4'b1001, 4'b1001, 1'b1, 1'b0};
      vecs[9]  = '{4'b0110, 1'b0, 4'b0110, 4'b0110, 1'b1, 1'b0};
      vecs[10] = '{4'b1000, 1'b1, 4'b1000, 4'b0001, 1'b1, 1'b0};

      rst = 1'b1;
      driveIdle();
      setReady(1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      $display("[TB] reset released");
      checkOutput("rst_valid_a",   {7'h0, a_if.out_valid}, 8'h0);
      checkOutput("rst_valid_b",   {7'h0, b_if.out_valid}, 8'h0);
      checkOutput("rst_data_a",    {4'h0, a_if.out_data},  8'h0);
      checkOutput("rst_data_b",    {4'h0, b_if.out_data},  8'h0);
      checkOutput("rst_nand_a",    {7'h0, nand_a},         8'h1);
      checkOutput("rst_overrun_a", {7'h0, ovr_a},          8'h0);
      checkOutput("rst_ready_a",   {7'h0, a_if.sin_ready}, 8'h1);
      checkOutput("rst_ready_b",   {7'h0, b_if.sin_ready}, 8'h1);

      // Single word, then confirm out_valid lasted exactly one cycle.
      applyStimulus(0, 1'b1, 1'b1);
      driveIdle();
      @(posedge clk);
      #1;
      checkOutput("valid_one_cycle_a", {7'h0, a_if.out_valid}, 8'h0);
      checkOutput("valid_one_cycle_b", {7'h0, b_if.out_valid}, 8'h0);

      applyStimulus(1, 1'b1, 1'b1);
      applyStimulus(2, 1'b1, 1'b1);
      applyStimulus(3, 1'b1, 1'b1);
      driveIdle();
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] backpressure phase");
      applyStimulus(4, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         driveBit(1'b1);
         #1;
         checkOutput("hold_sin_ready_a", {7'h0, a_if.sin_ready}, 8'h1);
         checkOutput("hold_sin_ready_b", {7'h0, b_if.sin_ready}, 8'h0);
         @(posedge clk);
         #1;
      end
      driveIdle();
      checkOutput("hold_data_a",    {4'h0, a_if.out_data},  8'h6);
      checkOutput("hold_data_b",    {4'h0, b_if.out_data},  8'h6);
      checkOutput("hold_valid_a",   {7'h0, a_if.out_valid}, 8'h1);
      checkOutput("hold_valid_b",   {7'h0, b_if.out_valid}, 8'h1);
      checkOutput("hold_overrun_a", {7'h0, ovr_a},          8'h1);
      checkOutput("hold_overrun_b", {7'h0, ovr_b},          8'h0);
      setReady(1'b1);
      @(posedge clk);
      #1;
      checkOutput("release_valid_a", {7'h0, a_if.out_valid}, 8'h0);
      checkOutput("release_valid_b", {7'h0, b_if.out_valid}, 8'h0);

      $display("[TB] streaming phase");
      applyStimulus(5, 1'b1, 1'b1);
      applyStimulus(6, 1'b1, 1'b1);
      applyStimulus(7, 1'b1, 1'b1);
      applyStimulus(8, 1'b1, 1'b1);
      driveIdle();
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] reset during hold");
      applyStimulus(10, 1'b0, 1'b0);
      driveIdle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_hold_valid_a",   {7'h0, a_if.out_valid}, 8'h0);
      checkOutput("rst_hold_valid_b",   {7'h0, b_if.out_valid}, 8'h0);
      checkOutput("rst_hold_data_a",    {4'h0, a_if.out_data},  8'h0);
      checkOutput("rst_hold_nand_a",    {7'h0, nand_a},         8'h1);
      checkOutput("rst_hold_overrun_a", {7'h0, ovr_a},          8'h0);
      setReady(1'b1);

      $display("[TB] reset mid-word");
      driveBit(1'b1);
      @(posedge clk);
      #1;
      driveBit(1'b1);
      @(posedge clk);
      #1;
      driveIdle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(9, 1'b1, 1'b1);
      driveIdle();
      repeat (3) @(posedge clk);
      #1;

      checkOutput("scoreboard_empty_a", qa.size() > 255 ? 8'hFF : 8'(qa.size()), 8'h0);
      checkOutput("scoreboard_empty_b", qb.size() > 255 ? 8'hFF : 8'(qb.size()), 8'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
